ysyx_23060136_ifu_fetch: RTL and testbench

//  Fetch front-end driving the IFU->IDU pipeline register.

---
 rtl/ysyx_23060136_ifu_pkg.sv | 27 ++
 rtl/ysyx_23060136_ifu_pc_gen.sv | 45 ++++
 rtl/ysyx_23060136_ifu_fetch.sv | 159 +++++++++++++++
 tb/tb_ysyx_23060136_ifu_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060136_ifu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_23060136_ifu_pkg: shared IFU fetch types and constants      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`ifndef ysyx_23060136_PC_RST
`define ysyx_23060136_PC_RST 32'h8000_0000
`endif
`ifndef ysyx_23060136_NOP
`define ysyx_23060136_NOP 32'h0000_0013
`endif

package ysyx_23060136_ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_e;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] IFU_PC_RST = `ysyx_23060136_PC_RST;
  localparam logic [31:0] IFU_NOP    = `ysyx_23060136_NOP;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060136_ifu_pc_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_23060136_ifu_pc_gen: PC register, next-PC mux               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ysyx_23060136_ifu_pc_gen
  import ysyx_23060136_ifu_pkg::*;
#(
  parameter int unsigned       BITS_W = 32,
  parameter logic [BITS_W-1:0] PC_RST = BITS_W'(IFU_PC_RST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [BITS_W-1:0] target_i,
  input  logic              advance_i,
  output logic [BITS_W-1:0] pc_o
);

  logic [BITS_W-1:0] pc_q;
  logic [BITS_W-1:0] pc_d;

  // Redirect wins over sequential advance; the add wraps modulo 2^BITS_W.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (advance_i) begin
      pc_d = pc_q + BITS_W'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RST;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060136_ifu_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_23060136_ifu_fetch: fetch FSM feeding the IFU/IDU register  |
// | Optional counters: YSYX_23060136_IFU_PERF_EN                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ysyx_23060136_ifu_fetch
  import ysyx_23060136_ifu_pkg::*;
#(
  parameter int unsigned       BITS_W = 32,
  parameter int unsigned       INST_W = 32,
  parameter logic [BITS_W-1:0] PC_RST = BITS_W'(IFU_PC_RST),
  parameter logic [INST_W-1:0] NOP    = INST_W'(IFU_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BRANCH_flushIF,
  input  logic [BITS_W-1:0] BRANCH_target,
  input  logic              FORWARD_stallID,
  output logic              IFU_o_req_valid,
  output logic [BITS_W-1:0] IFU_o_req_addr,
  input  logic              IFU_i_req_ready,
  input  logic              IFU_i_rsp_valid,
  input  logic [INST_W-1:0] IFU_i_rsp_data,
  output logic [BITS_W-1:0] IFU_o_pc,
  output logic [INST_W-1:0] IFU_o_inst,
  output logic              IFU_o_commit
`ifdef YSYX_23060136_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cnt,
  output logic [63:0]       perf_drop_cnt
`endif
);

  ifu_state_e        state_q;
  ifu_state_e        state_d;
  logic              req_valid_q;
  logic              drop_q;
  logic              drop_d;
  logic [BITS_W-1:0] out_pc_q;
  logic [INST_W-1:0] out_inst_q;
  logic              out_commit_q;
  logic [BITS_W-1:0] pc;

  logic flush;
  logic fire;
  logic rsp_wait;
  logic rsp_toss;
  logic rsp_keep;
  logic consume;

  // The IFU/IDU segment ignores a flush while stalled, so we do too.
  assign flush    = BRANCH_flushIF & ~FORWARD_stallID;
  assign fire     = (state_q == REQ) & req_valid_q & IFU_i_req_ready;
  assign rsp_wait = (state_q == WAIT) & IFU_i_rsp_valid;
  assign rsp_toss = rsp_wait & (drop_q | flush);
  assign rsp_keep = rsp_wait & ~rsp_toss;
  assign consume  = (state_q == HOLD) & ~FORWARD_stallID;

  ysyx_23060136_ifu_pc_gen #(
    .BITS_W (BITS_W),
    .PC_RST (PC_RST)
  ) u_pc_gen (
    .clk        (clk),
    .rst        (rst),
    .redirect_i (flush),
    .target_i   (BRANCH_target),
    .advance_i  (rsp_keep),
    .pc_o       (pc)
  );

  // An accepted request cannot be retracted: a flush after acceptance only
  // marks the in-flight response for discard.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    unique case (state_q)
      REQ: begin
        if (fire) begin
          state_d = WAIT;
          drop_d  = flush;
        end
      end
      WAIT: begin
        if (IFU_i_rsp_valid) begin
          state_d = rsp_toss ? REQ : HOLD;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (consume) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      out_pc_q     <= PC_RST;
      out_inst_q   <= NOP;
      out_commit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_valid_q <= (state_d == REQ);
      if (rsp_keep) begin
        out_pc_q     <= pc;
        out_inst_q   <= IFU_i_rsp_data;
        out_commit_q <= 1'b1;
      end else if (consume) begin
        out_pc_q     <= PC_RST;
        out_inst_q   <= NOP;
        out_commit_q <= 1'b0;
      end
    end
  end

  assign IFU_o_req_valid = req_valid_q;
  assign IFU_o_req_addr  = pc;
  assign IFU_o_pc        = out_pc_q;
  assign IFU_o_inst      = out_inst_q;
  assign IFU_o_commit    = out_commit_q;

`ifdef YSYX_23060136_IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] wait_cnt_q;
  logic [63:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 64'd0;
      wait_cnt_q  <= 64'd0;
      drop_cnt_q  <= 64'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {63'd0, rsp_keep};
      wait_cnt_q  <= wait_cnt_q + {63'd0, (state_q == WAIT)};
      drop_cnt_q  <= drop_cnt_q + {63'd0, rsp_toss};
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ysyx_23060136_ifu_fetch: scoreboard bench with memory model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ysyx_23060136_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] target;
  logic        stall;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        commit;
`ifdef YSYX_23060136_IFU_PERF_EN
  logic [63:0] pf_fetch;
  logic [63:0] pf_wait;
  logic [63:0] pf_drop;
`endif

  ysyx_23060136_ifu_fetch u_dut (
    .clk             (clk),
    .rst             (rst),
    .BRANCH_flushIF  (flush),
    .BRANCH_target   (target),
    .FORWARD_stallID (stall),
    .IFU_o_req_valid (req_valid),
    .IFU_o_req_addr  (req_addr),
    .IFU_i_req_ready (req_ready),
    .IFU_i_rsp_valid (rsp_valid),
    .IFU_i_rsp_data  (rsp_data),
    .IFU_o_pc        (o_pc),
    .IFU_o_inst      (o_inst),
    .IFU_o_commit    (commit)
`ifdef YSYX_23060136_IFU_PERF_EN
    ,
    .perf_fetch_cnt  (pf_fetch),
    .perf_wait_cnt   (pf_wait),
    .perf_drop_cnt   (pf_drop)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          mem_lat;
  int          tb_drops;
  logic        prev_commit;
  int          n_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : (a ^ 32'h5A5A_A5A5);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory model answers accepted requests after mem_lat cycles,
  // pushing the expected {pc,inst} unless the test announced a discard.
  task automatic tick();
    logic        fire_s;
    logic [31:0] fire_a;
    @(negedge clk);
    fire_s = req_valid && req_ready && !rst;
    fire_a = req_addr;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    if (fire_s) begin
      pend      = 1'b1;
      pend_addr = fire_a;
      pend_cnt  = mem_lat;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        pend      = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = mem_word(pend_addr);
        if (tb_drops > 0) tb_drops--;
        else exp_q.push_back({pend_addr, mem_word(pend_addr)});
      end else begin
        pend_cnt--;
      end
    end
    if (commit && !prev_commit) begin
      n_deliv++;
      if (exp_q.size() == 0) check("sb_unexpected_commit", commit, 1'b0);
      else check("sb_fetch", {o_pc, o_inst}, exp_q.pop_front());
    end
    prev_commit = commit;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_valid"}, req_valid, 1'b1);
  endtask

  task automatic wait_commit(input string tag);
    int n = 0;
    while (!commit && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_commit"}, commit, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; target = '0; stall = 1'b0; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = '0;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0; mem_lat = 0; tb_drops = 0;
    prev_commit = 1'b0; n_deliv = 0;
    repeat (3) tick();
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_addr", req_addr, 32'h8000_0000);
    check("rst_out", {o_pc, o_inst}, {32'h8000_0000, 32'h0000_0013});
    check("rst_commit", commit, 1'b0);

    // First fetch, then consume back to REQ.
    rst = 1'b0;
    wait_req("t1");
    check("t1_addr", req_addr, 32'h8000_0000);
    wait_commit("t1");
    tick();
    check("t1_next_valid", req_valid, 1'b1);
    check("t1_next_addr", req_addr, 32'h8000_0004);
    check("t1_bubble", {o_pc, o_inst}, {32'h8000_0000, 32'h0000_0013});
    check("t1_bubble_commit", commit, 1'b0);

    // Stall holds the presented instruction.
    stall = 1'b1;
    wait_commit("t2");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_rv", req_valid, 1'b0);
      check("t2_hold_out", {o_pc, o_inst}, {32'h8000_0004, mem_word(32'h8000_0004)});
      check("t2_hold_commit", commit, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("t2_release_rv", req_valid, 1'b1);
    check("t2_release_addr", req_addr, 32'h8000_0008);

    // Flush while waiting: in-flight response dropped.
    mem_lat = 2;
    tick();
    check("t3_in_wait", req_valid, 1'b0);
    flush = 1'b1; target = 32'h8000_0100; tb_drops = 1;
    tick();
    flush = 1'b0;
    wait_req("t3");
    check("t3_addr", req_addr, 32'h8000_0100);
    check("t3_commit_low", commit, 1'b0);
    mem_lat = 0;
    wait_commit("t3b");

    // Flush under stall is ignored; re-asserted without stall it redirects.
    stall = 1'b1; flush = 1'b1; target = 32'h9000_0000;
    tick();
    check("t4_ign_commit", commit, 1'b1);
    check("t4_ign_pc", o_pc, 32'h8000_0100);
    check("t4_ign_addr", req_addr, 32'h8000_0104);
    check("t4_ign_rv", req_valid, 1'b0);
    stall = 1'b0; req_ready = 1'b0;
    tick();
    flush = 1'b0;
    check("t4_redir_rv", req_valid, 1'b1);
    check("t4_redir_addr", req_addr, 32'h9000_0000);
    check("t4_redir_commit", commit, 1'b0);

    // Back-pressure on request; flush mid-way moves the address.
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        flush = 1'b1; target = 32'hA000_0000;
      end
      tick();
      flush = 1'b0;
      check("t5_rv", req_valid, 1'b1);
      check("t5_addr", req_addr, (i >= 1) ? 32'hA000_0000 : 32'h9000_0000);
    end
    req_ready = 1'b1;
    wait_commit("t5");

    // PC wrap, then reset while a response is outstanding.
    flush = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    check("t6_addr_top", req_addr, 32'hFFFF_FFFC);
    wait_commit("t6");
    tick();
    check("t6_wrap_rv", req_valid, 1'b1);
    check("t6_wrap_addr", req_addr, 32'h0000_0000);
    mem_lat = 3;
    tick();
    rst = 1'b1; req_ready = 1'b0; tb_drops = 1;
    tick();
    n_deliv = 0;
    check("t6_rst_addr", req_addr, 32'h8000_0000);
    check("t6_rst_rv", req_valid, 1'b0);
    check("t6_rst_commit", commit, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_late_commit", commit, 1'b0);
    end
    check("t6_late_addr", req_addr, 32'h8000_0000);
    check("t6_late_rv", req_valid, 1'b1);
    mem_lat = 0; req_ready = 1'b1;
    wait_commit("t6b");

    // Flush in the same cycle as the response discards it.
    tick();
    check("t7_req_addr", req_addr, 32'h8000_0004);
    tb_drops = 1;
    tick();
    flush = 1'b1; target = 32'hB000_0000;
    tick();
    flush = 1'b0;
    check("t7_rv", req_valid, 1'b1);
    check("t7_addr", req_addr, 32'hB000_0000);
    check("t7_commit", commit, 1'b0);
    wait_commit("t7");

    check("sb_empty", exp_q.size(), 0);
`ifdef YSYX_23060136_IFU_PERF_EN
    check("perf_fetch", pf_fetch, n_deliv);
    check("perf_drop", pf_drop, 1);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
